// File: rtl/sysref_gen_pkg.sv
// Shared types and defaults for the SYSREF pulse-train generator.
// Holds the FSM state encoding and the pulse-counter width.
package sysref_gen_pkg;

    localparam int unsigned SYSREF_CNT_W          = 8;
    localparam int unsigned SYSREF_PERIOD_CYC_DEF = 256;
    localparam int unsigned SYSREF_HIGH_CYC_DEF   = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArm   = 2'd1,
        StRun   = 2'd2,
        StDrain = 2'd3
    } sysref_state_t;

    // States in which the output may be driven high.
    function automatic logic sysref_active(input sysref_state_t s);
        return (s == StRun) || (s == StDrain);
    endfunction

endpackage

// File: rtl/sysref_gen_phase_cnt.sv
// Free-running SYSREF phase counter: 0..PERIOD_CYC-1, wraps to 0.
// o_wrap flags the last phase of each period.
module sysref_phase_cnt
    import sysref_gen_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = SYSREF_PERIOD_CYC_DEF,
    parameter int unsigned PH_W       = $clog2(PERIOD_CYC)
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic [PH_W-1:0] o_phase,
    output logic            o_wrap
);

    localparam logic [PH_W-1:0] LAST_PH = PH_W'(PERIOD_CYC - 1);

    logic [PH_W-1:0] r_phase;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_phase <= '0;
        end else if (o_wrap) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + 1'b1;
        end
    end

    assign o_phase = r_phase;
    assign o_wrap  = (r_phase == LAST_PH);

endmodule

// File: rtl/sysref_gen.sv
// Period-aligned SYSREF pulse-train generator (gapped or continuous).
// Define SYSREF_GEN_DIFF_OUT_EN to add sysref_p/sysref_n through an OBUFDS.
module sysref_gen
    import sysref_gen_pkg::*;
#(
    parameter int unsigned PERIOD_CYC = SYSREF_PERIOD_CYC_DEF,
    parameter int unsigned HIGH_CYC   = SYSREF_HIGH_CYC_DEF
) (
    input  logic                    pl_clk,
    input  logic                    pl_rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic [SYSREF_CNT_W-1:0] pulse_count,
    output logic                    sysref_out,
`ifdef SYSREF_GEN_DIFF_OUT_EN
    output logic                    sysref_p,
    output logic                    sysref_n,
`endif
    output logic                    pulse_strobe,
    output logic                    busy,
    output logic                    done
);

    localparam int unsigned     PH_W    = $clog2(PERIOD_CYC);
    localparam logic [PH_W-1:0] HIGH_PH = PH_W'(HIGH_CYC);

    logic [PH_W-1:0]         w_phase;
    logic [PH_W-1:0]         w_phase_nxt;
    logic                    w_wrap;

    sysref_state_t           r_state;
    sysref_state_t           w_state_d;
    logic [SYSREF_CNT_W-1:0] r_cnt_lat;
    logic [SYSREF_CNT_W-1:0] w_cnt_lat_d;
    logic [SYSREF_CNT_W-1:0] r_pulse_cnt;
    logic [SYSREF_CNT_W-1:0] w_pulse_cnt_d;
    logic                    r_sysref;
    logic                    w_sysref_d;
    logic                    r_strobe;
    logic                    w_strobe_d;
    logic                    r_done;
    logic                    w_done_d;
    logic                    w_last_pulse;
    logic                    w_pulse_start;

    sysref_phase_cnt #(
        .PERIOD_CYC (PERIOD_CYC),
        .PH_W       (PH_W)
    ) u_phase_cnt (
        .i_clk   (pl_clk),
        .i_rst   (pl_rst),
        .o_phase (w_phase),
        .o_wrap  (w_wrap)
    );

    // Output register is fed from the upcoming phase so it is high exactly
    // while the phase counter sits in 0..HIGH_CYC-1.
    assign w_phase_nxt = w_wrap ? '0 : w_phase + 1'b1;

    always_comb begin
        w_state_d     = r_state;
        w_cnt_lat_d   = r_cnt_lat;
        w_pulse_cnt_d = r_pulse_cnt;
        w_last_pulse  = (r_cnt_lat != '0) && (r_pulse_cnt >= r_cnt_lat);

        unique case (r_state)
            StIdle: begin
                if (start && !stop) begin
                    w_state_d     = StArm;
                    w_cnt_lat_d   = pulse_count;
                    w_pulse_cnt_d = '0;
                end
            end
            StArm: begin
                if (stop) begin
                    w_state_d = StIdle;
                end else if (w_wrap) begin
                    w_state_d = StRun;
                end
            end
            StRun: begin
                if (stop) begin
                    w_state_d = r_sysref ? StDrain : StIdle;
                end else if (w_last_pulse && (w_phase == HIGH_PH)) begin
                    // One cycle after the falling edge of the final pulse.
                    w_state_d = StIdle;
                end
            end
            StDrain: begin
                if (!r_sysref) begin
                    w_state_d = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        w_pulse_start = (w_state_d == StRun) && (w_phase_nxt == '0);
        if (w_pulse_start && (r_pulse_cnt != '1)) begin
            w_pulse_cnt_d = r_pulse_cnt + 1'b1;
        end

        w_sysref_d = sysref_active(w_state_d) && (w_phase_nxt < HIGH_PH);
        w_strobe_d = w_pulse_start;
        w_done_d   = (r_state != StIdle) && (w_state_d == StIdle);
    end

    always_ff @(posedge pl_clk) begin
        if (pl_rst) begin
            r_state     <= StIdle;
            r_cnt_lat   <= '0;
            r_pulse_cnt <= '0;
            r_sysref    <= 1'b0;
            r_strobe    <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_cnt_lat   <= w_cnt_lat_d;
            r_pulse_cnt <= w_pulse_cnt_d;
            r_sysref    <= w_sysref_d;
            r_strobe    <= w_strobe_d;
            r_done      <= w_done_d;
        end
    end

    assign sysref_out   = r_sysref;
    assign pulse_strobe = r_strobe;
    assign busy         = (r_state != StIdle);
    assign done         = r_done;

`ifdef SYSREF_GEN_DIFF_OUT_EN
    OBUFDS u_obufds (
        .I  (r_sysref),
        .O  (sysref_p),
        .OB (sysref_n)
    );
`endif

endmodule

// File: tb/tb_sysref_gen.sv
// Scoreboard bench for sysref_gen with PERIOD_CYC=16, HIGH_CYC=4.
// Expected per-cycle outputs are queued at stimulus time and popped each negedge.
module tb_sysref_gen;

    localparam int PER = 16;
    localparam int HI  = 4;

    typedef struct {
        logic sysref;
        logic strobe;
        logic busy;
        logic done;
        bit   chk_bd;
    } exp_t;

    logic       clk;
    logic       pl_rst;
    logic       start;
    logic       stop;
    logic [7:0] pulse_count;
    logic       sysref_out;
    logic       pulse_strobe;
    logic       busy;
    logic       done;
`ifdef SYSREF_GEN_DIFF_OUT_EN
    logic       sysref_p;
    logic       sysref_n;
`endif

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   done_seen = 0;
    int   tb_phase  = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    sysref_gen #(
        .PERIOD_CYC (PER),
        .HIGH_CYC   (HI)
    ) u_dut (
        .pl_clk       (clk),
        .pl_rst       (pl_rst),
        .start        (start),
        .stop         (stop),
        .pulse_count  (pulse_count),
        .sysref_out   (sysref_out),
`ifdef SYSREF_GEN_DIFF_OUT_EN
        .sysref_p     (sysref_p),
        .sysref_n     (sysref_n),
`endif
        .pulse_strobe (pulse_strobe),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference phase: free-running, cleared by reset.
    always @(posedge clk) tb_phase <= pl_rst ? 0 : (tb_phase + 1) % PER;

    task automatic chk(input string tag, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            mon_e = sb_q.pop_front();
            chk("sysref_out", int'(sysref_out), int'(mon_e.sysref));
            chk("pulse_strobe", int'(pulse_strobe), int'(mon_e.strobe));
            if (mon_e.chk_bd) begin
                chk("busy", int'(busy), int'(mon_e.busy));
                chk("done", int'(done), int'(mon_e.done));
            end
            if (done) done_seen++;
`ifdef SYSREF_GEN_DIFF_OUT_EN
            chk("sysref_p", int'(sysref_p), int'(mon_e.sysref));
            chk("sysref_n", int'(sysref_n), int'(!mon_e.sysref));
`endif
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_phase(input int p);
        int n;
        n = 0;
        next_cycle();
        while (tb_phase != p && n < 40) begin
            next_cycle();
            n++;
        end
        if (tb_phase != p) chk("wait_phase", tb_phase, p);
    endtask

    // Offset d=0 is the current cycle; pulse k occupies f+PER*k .. f+PER*k+HI-1.
    task automatic push_exp(input int total, input int f, input int npulse, input int busy_end,
                            input int done_off, input int skip_lo, input int skip_hi);
        for (int d = 0; d < total; d++) begin
            exp_t e;
            int   k;
            k        = d - f;
            e.sysref = (k >= 0) && ((k % PER) < HI) && ((k / PER) < npulse);
            e.strobe = (k >= 0) && ((k % PER) == 0) && ((k / PER) < npulse);
            e.busy   = (d >= 1) && (d < busy_end);
            e.done   = (d == done_off);
            e.chk_bd = !((d >= skip_lo) && (d <= skip_hi));
            sb_q.push_back(e);
        end
    endtask

    task automatic run_scn(input string name, input int ps, input int cnt, input int both,
                           input int total, input int npulse, input int busy_end,
                           input int done_off, input int skip_lo, input int skip_hi,
                           input int stop_off, input int stop2_off, input int start2_off,
                           input int rst_off, input int done_n);
        int w;
        wait_phase(ps);
        // ARM leaves on the first phase PER-1 seen after start; the pulse follows.
        w = (PER - 1) - ps;
        if (w < 1) w += PER;
        start       = 1'b1;
        stop        = both[0];
        pulse_count = 8'(cnt);
        done_seen   = 0;
        push_exp(total, w + 1, npulse, busy_end, done_off, skip_lo, skip_hi);
        for (int d = 1; d < total; d++) begin
            next_cycle();
            start  = 1'b0;
            stop   = 1'b0;
            pl_rst = 1'b0;
            if (d == stop_off || d == stop2_off) stop = 1'b1;
            if (d == start2_off) begin
                start       = 1'b1;
                pulse_count = 8'd7;
            end
            if (d == rst_off) pl_rst = 1'b1;
        end
        next_cycle();
        start  = 1'b0;
        stop   = 1'b0;
        pl_rst = 1'b0;
        chk({name, "_done_count"}, done_seen, done_n);
    endtask

    initial begin
        pl_rst      = 1'b1;
        start       = 1'b0;
        stop        = 1'b0;
        pulse_count = 8'd0;
        repeat (3) next_cycle();
        chk("rst_sysref", int'(sysref_out), 0);
        chk("rst_strobe", int'(pulse_strobe), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_phase", int'(u_dut.u_phase_cnt.o_phase), 0);
        pl_rst = 1'b0;

        // 3 gapped pulses from phase 5; a start while running is ignored.
        run_scn("gapped3", 5, 3, 0, 60, 3, 48, 48, 1, 0, -1, -1, 20, -1, 1);
        // Continuous; stop on 2nd high cycle of 5th pulse, second stop lands in DRAIN.
        run_scn("cont_drain", 10, 0, 0, 90, 5, 74, 75, 74, 75, 71, 72, -1, -1, 1);
        // Stop while armed: no pulse.
        run_scn("arm_stop", 3, 0, 0, 30, 0, 6, 6, 1, 0, 5, -1, -1, -1, 1);
        // Start and stop together in IDLE: nothing happens.
        run_scn("start_stop", 7, 2, 1, 30, 0, 0, -1, 1, 0, -1, -1, -1, -1, 0);
        // Continuous; stop while output low ends immediately.
        run_scn("cont_low_stop", 2, 0, 0, 55, 2, 39, 39, 1, 0, 38, -1, -1, -1, 1);
        // Longest and shortest start-to-rise latency.
        run_scn("late_start", 15, 2, 0, 50, 2, 38, 38, 1, 0, -1, -1, -1, -1, 1);
        run_scn("early_start", 14, 1, 0, 20, 1, 7, 7, 1, 0, -1, -1, -1, -1, 1);

        // Reset on the 2nd high cycle of a pulse: output drops, no done.
        run_scn("mid_rst", 12, 0, 0, 6, 1, 6, -1, 1, 0, -1, -1, -1, 5, 0);
        chk("mid_rst_phase", int'(u_dut.u_phase_cnt.o_phase), 0);
        push_exp(20, 1000, 0, 0, -1, 1, 0);
        repeat (20) next_cycle();
        chk("mid_rst_done_after", done_seen, 0);

        next_cycle();
        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
